// File: rtl/t10_tx_arb_pkg.sv
// t10_tx_arb_pkg -- shared types and constants for the two-requester UART
// transmit arbiter.
//   state_t   : arbiter FSM states (IDLE, SEND, DONE)
//   req_id_t  : requester identity (REQ_A, REQ_B)
//   TIMEOUT_CYCLES_DEF : default SEND timeout used when the timeout option
//                        (T10_TX_ARB_TIMEOUT_EN) is compiled in.
package t10_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/t10_rr_arb2.sv
// t10_rr_arb2 -- combinational two-way round-robin selector.
// Ports:
//   req_a, req_b : request lines
//   last_grant   : requester served most recently
//   grant        : selected requester (meaningful when valid=1)
//   valid        : at least one request present
// On a tie the requester that was not served last wins; a lone requester
// always wins regardless of history.
module t10_rr_arb2
  import t10_tx_arb_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last_grant,
  output req_id_t grant,
  output logic    valid
);

  always_comb begin
    grant = REQ_A;
    if (req_a && req_b)
      grant = (last_grant == REQ_A) ? REQ_B : REQ_A;
    else if (req_b)
      grant = REQ_B;
  end

  assign valid = req_a | req_b;

endmodule

// File: rtl/t10_tx_arbiter.sv
// t10_tx_arbiter -- arbitrates two byte requesters onto one UART transmitter.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_a/data_a/ack_a : requester A handshake (req held until ack pulse)
//   req_b/data_b/ack_b : requester B handshake
//   transmit_ready     : UART pulse, current byte sent
//   tx_ctrl, tx_byte   : UART transmit enable and byte
//   busy               : FSM not in IDLE
//   blue               : one-cycle pulse on successful completion
//   timeout_err        : sticky SEND-timeout flag (T10_TX_ARB_TIMEOUT_EN only)
// Option macro: T10_TX_ARB_TIMEOUT_EN adds a SEND watchdog of TIMEOUT_CYCLES.
// Every output is a register; a byte takes at least SEND, DONE, IDLE cycles.
module t10_tx_arbiter
  import t10_tx_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  output logic       ack_b,
  input  logic       transmit_ready,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       blue
`ifdef T10_TX_ARB_TIMEOUT_EN
  ,output logic      timeout_err
`endif
);

  state_t  state;
  req_id_t last_grant;
  req_id_t cur_grant;   // who owns the byte in flight; becomes last_grant on leaving DONE
  req_id_t arb_grant;
  logic    arb_valid;
  logic    tmo_hit;

  t10_rr_arb2 u_rr (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

`ifdef T10_TX_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;

  // Counts SEND cycles; zero in the first SEND cycle.
  always_ff @(posedge clk) begin
    if (rst || state != SEND) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + CW'(1);
  end

  assign tmo_hit = (state == SEND) && (tmo_cnt == TMO_LAST);
`else
  // Parameter stays on the interface so both builds share one instantiation.
  logic unused_tmo_param;
  assign unused_tmo_param = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_B;
      cur_grant  <= REQ_B;
      tx_ctrl    <= 1'b0;
      tx_byte    <= 8'h00;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      busy       <= 1'b0;
      blue       <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      blue  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state     <= SEND;
            tx_ctrl   <= 1'b1;
            busy      <= 1'b1;
            cur_grant <= arb_grant;
            if (arb_grant == REQ_A) begin
              tx_byte <= data_a;
              ack_a   <= 1'b1;
            end else begin
              tx_byte <= data_b;
              ack_b   <= 1'b1;
            end
          end
        end
        SEND: begin
          // transmit_ready beats a simultaneous timeout expiry
          if (transmit_ready) begin
            state   <= DONE;
            tx_ctrl <= 1'b0;
            blue    <= 1'b1;
          end else if (tmo_hit) begin
            state   <= DONE;
            tx_ctrl <= 1'b0;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          last_grant <= cur_grant;
        end
        default: begin
          state   <= IDLE;
          tx_ctrl <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef T10_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst)                            timeout_err <= 1'b0;
    else if (tmo_hit && !transmit_ready) timeout_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_t10_tx_arbiter.sv
// tb_t10_tx_arbiter -- directed self-checking bench for t10_tx_arbiter.
// Inputs change and outputs are sampled on the falling clock edge.
// Timeout scenarios are built only with T10_TX_ARB_TIMEOUT_EN.
module tb_t10_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b, transmit_ready;
  logic [7:0] data_a, data_b;
  logic       ack_a, ack_b, tx_ctrl, busy, blue;
  logic [7:0] tx_byte;
`ifdef T10_TX_ARB_TIMEOUT_EN
  logic       timeout_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  t10_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_a          (req_a),
    .data_a         (data_a),
    .ack_a          (ack_a),
    .req_b          (req_b),
    .data_b         (data_b),
    .ack_b          (ack_b),
    .transmit_ready (transmit_ready),
    .tx_ctrl        (tx_ctrl),
    .tx_byte        (tx_byte),
    .busy           (busy),
    .blue           (blue)
`ifdef T10_TX_ARB_TIMEOUT_EN
    ,.timeout_err   (timeout_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for an ack pulse; reports which requester was acked.
  task automatic wait_ack(output logic got_a, output logic got_b);
    logic seen;
    seen  = 1'b0;
    got_a = 1'b0;
    got_b = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        seen  = 1'b1;
        got_a = ack_a;
        got_b = ack_b;
      end
    end
    chk("ack_seen", {31'd0, seen}, 32'd1);
  endtask

  // Pulse transmit_ready in SEND; next sample is the DONE cycle.
  task automatic finish_send();
    transmit_ready = 1'b1;
    @(negedge clk);
    transmit_ready = 1'b0;
    chk("done_blue", {31'd0, blue}, 32'd1);
    chk("done_txctrl", {31'd0, tx_ctrl}, 32'd0);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ga, gb;
    logic [7:0] exp_bytes [3];
    req_a = 0; req_b = 0; transmit_ready = 0; data_a = 0; data_b = 0; rst = 1;
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_txctrl", {31'd0, tx_ctrl}, 32'd0);
    chk("rst_txbyte", {24'd0, tx_byte}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_acks",   {30'd0, ack_a, ack_b}, 32'd0);
    chk("rst_blue",   {31'd0, blue}, 32'd0);

    // single A transfer
    req_a = 1; data_a = 8'h41;
    @(negedge clk);
    chk("a_txbyte", {24'd0, tx_byte}, 32'h41);
    chk("a_ack",    {30'd0, ack_a, ack_b}, 32'd2);
    chk("a_txctrl", {31'd0, tx_ctrl}, 32'd1);
    chk("a_busy",   {31'd0, busy}, 32'd1);
    req_a = 0;
    @(negedge clk);
    chk("a_ack_pulse", {31'd0, ack_a}, 32'd0);
    chk("a_hold_byte", {24'd0, tx_byte}, 32'h41);
    finish_send();
    @(negedge clk);
    chk("a_blue_pulse", {31'd0, blue}, 32'd0);

    // round robin with both held
    do_reset();
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h11;
    req_a = 1; req_b = 1; data_a = 8'h11; data_b = 8'h22;
    for (int k = 0; k < 3; k++) begin
      wait_ack(ga, gb);
      chk("rr_overlap", {31'd0, ga & gb}, 32'd0);
      chk("rr_byte", {24'd0, tx_byte}, {24'd0, exp_bytes[k]});
      chk("rr_who", {31'd0, gb}, (k == 1) ? 32'd1 : 32'd0);
      finish_send();
    end
    req_a = 0; req_b = 0;

    // reset two cycles into SEND
    do_reset();
    req_a = 1; data_a = 8'h5A;
    @(negedge clk);
    chk("abort_byte", {24'd0, tx_byte}, 32'h5A);
    req_a = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_txctrl", {31'd0, tx_ctrl}, 32'd0);
    chk("abort_txbyte", {24'd0, tx_byte}, 32'd0);
    chk("abort_busy",   {31'd0, busy}, 32'd0);
    transmit_ready = 1;
    @(negedge clk);
    transmit_ready = 0;
    @(negedge clk);
    chk("abort_blue", {31'd0, blue}, 32'd0);
    chk("abort_idle", {30'd0, busy, tx_ctrl}, 32'd0);

    // transmit_ready in IDLE with req_b arriving; late req_a must wait
    transmit_ready = 1; req_b = 1; data_b = 8'h77;
    @(negedge clk);
    transmit_ready = 0; req_b = 0;
    chk("b_ack",    {30'd0, ack_a, ack_b}, 32'd1);
    chk("b_byte",   {24'd0, tx_byte}, 32'h77);
    req_a = 1; data_a = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b_hold_txctrl", {31'd0, tx_ctrl}, 32'd1);
      chk("b_wait_acka",   {31'd0, ack_a}, 32'd0);
    end
    transmit_ready = 1;
    @(negedge clk);
    transmit_ready = 0;
    chk("b_blue", {31'd0, blue}, 32'd1);
    chk("b_done_acka", {31'd0, ack_a}, 32'd0);
    @(negedge clk);
    chk("b_idle_acka", {31'd0, ack_a}, 32'd0);
    @(negedge clk);
    chk("late_a_ack",  {31'd0, ack_a}, 32'd1);
    chk("late_a_byte", {24'd0, tx_byte}, 32'h33);
    req_a = 0;
    finish_send();

    // lone requester wins even though it was served last
    req_a = 1; data_a = 8'h0F;
    @(negedge clk);
    chk("lone_a_ack", {30'd0, ack_a, ack_b}, 32'd2);
    req_a = 0;
    finish_send();

`ifdef T10_TX_ARB_TIMEOUT_EN
    // timeout abort after 16 SEND cycles
    do_reset();
    req_a = 1; data_a = 8'h99;
    @(negedge clk);
    chk("tmo_ack", {31'd0, ack_a}, 32'd1);
    req_a = 0;
    repeat (15) @(negedge clk);
    chk("tmo_still_send", {31'd0, tx_ctrl}, 32'd1);
    chk("tmo_err_pre",    {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    chk("tmo_txctrl", {31'd0, tx_ctrl}, 32'd0);
    chk("tmo_blue",   {31'd0, blue}, 32'd0);
    chk("tmo_err",    {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    req_b = 1; data_b = 8'h55;
    @(negedge clk);
    chk("tmo_b_ack", {31'd0, ack_b}, 32'd1);
    req_b = 0;
    finish_send();
    chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
    do_reset();
    chk("tmo_err_clr", {31'd0, timeout_err}, 32'd0);

    // transmit_ready exactly at expiry wins
    req_a = 1; data_a = 8'hC3;
    @(negedge clk);
    req_a = 0;
    repeat (15) @(negedge clk);
    transmit_ready = 1;
    @(negedge clk);
    transmit_ready = 0;
    chk("edge_blue", {31'd0, blue}, 32'd1);
    chk("edge_err",  {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
